// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter for the register bank write port,
// with a 31-step sweep that zeroes registers 1..NREG-1.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   reqN_valid/addr/data     writeback request from requester N (0,1)
//   reqN_ready               request accepted this cycle (combinational)
//   clr_start                one-cycle pulse starting a register clear
//   clr_busy                 clear sweep in progress (registered)
//   we, a3, wd3              registered bank write enable/address/data
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              we,
    output logic [ADDR_W-1:0] a3,
    output logic [DATA_W-1:0] wd3
);

    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state, state_n;
    logic              ptr, ptr_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              we_n, busy_n;
    logic [ADDR_W-1:0] a3_n;
    logic [DATA_W-1:0] wd3_n;
    logic              arb;

    assign arb = (state == ARB);

    // ptr only matters when both requesters are valid.
    assign req0_ready = arb & req0_valid & ~clr_start
                      & (~req1_valid | ~ptr);
    assign req1_ready = arb & req1_valid & ~clr_start
                      & (~req0_valid | ptr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB;
            ptr      <= 1'b0;
            cnt      <= '0;
            we       <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
            clr_busy <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            we       <= we_n;
            a3       <= a3_n;
            wd3      <= wd3_n;
            clr_busy <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        we_n    = 1'b0;
        a3_n    = a3;
        wd3_n   = wd3;
        busy_n  = clr_busy;
        unique case (state)
            ARB: begin
                unique case (1'b1)
                    clr_start: begin
                        state_n = CLEAR;
                        cnt_n   = ONE;
                        we_n    = 1'b1;
                        a3_n    = ONE;
                        wd3_n   = '0;
                        busy_n  = 1'b1;
                    end
                    req0_ready: begin
                        ptr_n = 1'b1;
                        a3_n  = req0_addr;
                        wd3_n = req0_data;
                        // register 0 is hardwired: accept, never write
                        we_n  = |req0_addr;
                    end
                    req1_ready: begin
                        ptr_n = 1'b0;
                        a3_n  = req1_addr;
                        wd3_n = req1_data;
                        we_n  = |req1_addr;
                    end
                    default: ;
                endcase
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    state_n = ARB;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt + ONE;
                    a3_n  = cnt + ONE;
                    wd3_n = '0;
                    we_n  = 1'b1;
                end
            end
            default: state_n = ARB;
        endcase
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed + randomized bench for rf_write_arbiter.
// Reference model tracks grants, pointer and clear progress as integers.
module tb_rf_write_arbiter;

    localparam int NREG = 32;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        clr_start;
    logic        clr_busy;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;

    rf_write_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .we         (we),
        .a3         (a3),
        .wd3        (wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model: m_step=0 means arbitrating, otherwise the clear index on a3
    int          m_step;
    bit          m_ptr;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    int          last_grant;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_step = 0;
        m_ptr  = 1'b0;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd3  = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, {31'd0, we}, 32'd0);
        check({tag, "_a3"}, {27'd0, a3}, 32'd0);
        check({tag, "_wd3"}, wd3, 32'd0);
        check({tag, "_busy"}, {31'd0, clr_busy}, 32'd0);
    endtask

    // Called at posedge+1 with inputs applied; returns at next posedge+1.
    task automatic step();
        int g;
        #1;
        g = -1;
        if (m_step == 0 && !clr_start) begin
            if (req0_valid && req1_valid) g = m_ptr ? 1 : 0;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        check("rdy0", {31'd0, req0_ready}, {31'd0, g == 0});
        check("rdy1", {31'd0, req1_ready}, {31'd0, g == 1});
        last_grant = g;
        if (m_step != 0) begin
            if (m_step == NREG - 1) begin
                m_step = 0;
                m_we   = 1'b0;
            end else begin
                m_step = m_step + 1;
                m_a3   = 5'(m_step);
                m_wd3  = '0;
                m_we   = 1'b1;
            end
        end else if (clr_start) begin
            m_step = 1;
            m_a3   = 5'd1;
            m_wd3  = '0;
            m_we   = 1'b1;
        end else if (g == 0) begin
            m_a3  = req0_addr;
            m_wd3 = req0_data;
            m_we  = (req0_addr != 0);
            m_ptr = 1'b1;
        end else if (g == 1) begin
            m_a3  = req1_addr;
            m_wd3 = req1_data;
            m_we  = (req1_addr != 0);
            m_ptr = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        #1;
        check("we", {31'd0, we}, {31'd0, m_we});
        check("a3", {27'd0, a3}, {27'd0, m_a3});
        check("wd3", wd3, m_wd3);
        check("busy", {31'd0, clr_busy}, {31'd0, m_step != 0});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check_zero("rst");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic idle();
        req0_valid = 0;
        req1_valid = 0;
        clr_start  = 0;
    endtask

    initial begin
        bit p0, p1;
        reset_n   = 1'b0;
        req0_addr = '0;
        req1_addr = '0;
        req0_data = '0;
        req1_data = '0;
        idle();
        model_reset();
        last_grant = -1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        reset_n = 1'b1;

        // reset state, no requests
        for (int i = 0; i < 10; i++) step();
        check_zero("idle");

        // single req0 write
        req0_valid = 1;
        req0_addr  = 5'd5;
        req0_data  = 32'hDEADBEEF;
        step();
        check("t2_grant", last_grant, 0);
        check("t2_we", {31'd0, we}, 32'd1);
        check("t2_a3", {27'd0, a3}, 32'd5);
        check("t2_wd3", wd3, 32'hDEADBEEF);
        idle();
        step();
        check("t2_we_off", {31'd0, we}, 32'd0);

        // alternation from a fresh pointer
        do_reset();
        req0_valid = 1;
        req1_valid = 1;
        req0_addr  = 5'd1;
        req1_addr  = 5'd2;
        req0_data  = 32'h11;
        req1_data  = 32'h22;
        for (int i = 0; i < 6; i++) begin
            step();
            check("alt_grant", last_grant, i % 2);
            check("alt_a3", {27'd0, a3}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle();
        step();

        // write to r0 is dropped but still flips the pointer
        req0_valid = 1;
        req0_addr  = 5'd7;
        step();
        idle();
        req1_valid = 1;
        req1_addr  = 5'd0;
        req1_data  = 32'h1234;
        step();
        check("r0_grant", last_grant, 1);
        check("r0_we", {31'd0, we}, 32'd0);
        req0_valid = 1;
        req0_addr  = 5'd3;
        step();
        check("r0_next", last_grant, 0);
        idle();

        // clear sweep with pending requests and an ignored restart
        do_reset();
        req0_valid = 1;
        req1_valid = 1;
        req0_addr  = 5'd9;
        req1_addr  = 5'd10;
        clr_start  = 1;
        step();
        for (int i = 1; i < NREG; i++) begin
            check("clr_a3", {27'd0, a3}, i);
            check("clr_we", {31'd0, we}, 32'd1);
            clr_start = (i == 10);
            step();
        end
        clr_start = 0;
        check("clr_end_busy", {31'd0, clr_busy}, 32'd0);
        step();
        check("clr_after", last_grant, 0);
        check("clr_after_a3", {27'd0, a3}, 32'd9);
        idle();
        step();

        // asynchronous reset in the middle of a sweep
        clr_start = 1;
        step();
        clr_start = 0;
        while (a3 != 5'd12 && m_step != 0) step();
        check("mid_a3", {27'd0, a3}, 32'd12);
        do_reset();
        req1_valid = 1;
        req1_addr  = 5'd4;
        req1_data  = 32'hCAFE0004;
        step();
        check("post_rst", last_grant, 1);
        check("post_rst_a3", {27'd0, a3}, 32'd4);
        idle();

        // randomized traffic; requesters hold a request until granted
        p0 = 0;
        p1 = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!p0 && ($urandom % 3 == 0)) begin
                p0 = 1;
                req0_addr = 5'($urandom % 32);
                req0_data = $urandom;
            end
            if (!p1 && ($urandom % 3 == 0)) begin
                p1 = 1;
                req1_addr = 5'($urandom % 32);
                req1_data = $urandom;
            end
            req0_valid = p0;
            req1_valid = p1;
            clr_start  = ($urandom % 60 == 0);
            step();
            if (last_grant == 0) p0 = 0;
            if (last_grant == 1) p1 = 0;
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
